// File: rtl/rx_frame_fifo.sv
// Store-and-forward frame FIFO: Avalon-ST words are buffered tentatively and
// become readable only once the frame ends with a clean eop; bad frames are dropped and counted.
module rx_frame_fifo #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [1:0]            in_empty,
  input  logic                  in_error,
  output logic                  in_ready,
  input  logic                  rdreq,
  output logic                  rdempty,
  output logic [DATA_W-1:0]     q_data,
  output logic                  q_sop,
  output logic                  q_eop,
  output logic [1:0]            q_empty,
  input  logic                  clear,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int ENT_W = DATA_W + 4;
  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [ENT_W-1:0]  mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_nxt, commit_nxt, rd_nxt, wbase;
  logic [1:0]        state, state_nxt;
  logic              acc, wr_req, full, do_write, pop;
  logic [1:0]        drops;
  logic [DROP_CNT_W:0] drop_sum;
  logic [ENT_W-1:0]  head;

  // A new sop always restarts at commit_ptr, which also rolls back any truncated frame.
  always_comb begin
    acc        = in_valid && in_ready;
    wr_req     = acc && (in_sop || state == WRITE);
    wbase      = in_sop ? commit_ptr : wr_ptr;
    full       = (wbase + ONE) == rd_ptr;
    do_write   = wr_req && !full;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    state_nxt  = state;
    drops      = 2'd0;
    if (wr_req) begin
      if (state == WRITE && in_sop) drops = 2'd1;
      if (full) begin
        wr_nxt    = commit_ptr;
        drops     = drops + 2'd1;
        state_nxt = in_eop ? IDLE : DROP;
      end else if (in_eop) begin
        state_nxt = IDLE;
        if (in_error) begin
          wr_nxt = commit_ptr;
          drops  = drops + 2'd1;
        end else begin
          wr_nxt     = wbase + ONE;
          commit_nxt = wbase + ONE;
        end
      end else begin
        wr_nxt    = wbase + ONE;
        state_nxt = WRITE;
      end
    end else if (acc && state == DROP && in_eop) begin
      state_nxt = IDLE;
    end
    pop      = rdreq && !rdempty;
    rd_nxt   = pop ? rd_ptr + ONE : rd_ptr;
    drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drops);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
      in_ready   <= 1'b0;
      rdempty    <= 1'b1;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      rd_ptr     <= rd_nxt;
      state      <= state_nxt;
      in_ready   <= 1'b1;
      rdempty    <= (rd_nxt == commit_nxt);
      if (clear)                   drop_count <= '0;
      else if (drop_sum[DROP_CNT_W]) drop_count <= '1;
      else                         drop_count <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (do_write) mem[wbase] <= {in_data, in_sop, in_eop, in_empty};
  end

  always_comb begin
    head = rdempty ? '0 : mem[rd_ptr];
    {q_data, q_sop, q_eop, q_empty} = head;
  end
endmodule

// File: tb/tb_rx_frame_fifo.sv
// Scoreboard bench for rx_frame_fifo: stimulus queues expected words, a
// negedge monitor pops the DUT and compares against the queue.
module tb_rx_frame_fifo;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_error, in_ready;
  logic [1:0]  in_empty;
  logic        rdreq, rdempty, q_sop, q_eop, clear;
  logic [31:0] q_data;
  logic [1:0]  q_empty;
  logic [1:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  bit mon_en = 1'b0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_fifo #(.DATA_W(32), .ADDR_W(4), .DROP_CNT_W(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .rdreq(rdreq), .rdempty(rdempty),
    .q_data(q_data), .q_sop(q_sop), .q_eop(q_eop), .q_empty(q_empty),
    .clear(clear), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a word is presented, compare it with the queue head and pop it.
  initial begin
    logic [35:0] e;
    rdreq = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && n_rst && !rdempty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {q_data, q_sop, q_eop, q_empty});
        end else begin
          e = exp_q.pop_front();
          check("rd_word", 64'({q_data, q_sop, q_eop, q_empty}), 64'(e));
        end
        rdreq = 1'b1;
      end else begin
        rdreq = 1'b0;
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_error = 1'b0; in_empty = 2'd0; in_data = '0;
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] emp, input logic er);
    in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_error = er; in_valid = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  // Frame of n words, data = seed+i, empty=3 on eop; queued when expected to survive.
  task automatic frame(input int n, input logic [31:0] seed, input logic err, input bit good);
    for (int i = 0; i < n; i++) begin
      logic s, e;
      logic [1:0] emp;
      s = (i == 0);
      e = (i == n - 1);
      emp = e ? 2'd3 : 2'd0;
      if (good) exp_q.push_back({seed + 32'(i), s, e, emp});
      send(seed + 32'(i), s, e, emp, e ? err : 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    clear = 1'b0;
    n_rst = 1'b0;
    // 1: reset with valid held high
    in_valid = 1'b1; in_sop = 1'b1; in_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdempty", 64'(rdempty), 64'd1);
    check("rst_q_data", 64'(q_data), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("empty_after_rst", 64'(rdempty), 64'd1);

    // 2: good frame, commit latency observed with the monitor off
    send(32'h641225EB, 1'b1, 1'b0, 2'd0, 1'b0);
    check("t2_empty_w0", 64'(rdempty), 64'd1);
    send(32'h1080809B, 1'b0, 1'b0, 2'd0, 1'b0);
    in_data = 32'h203D1474; in_sop = 1'b0; in_eop = 1'b1; in_empty = 2'd2; in_valid = 1'b1;
    #3;
    check("t2_empty_eop_cycle", 64'(rdempty), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    check("t2_empty_next", 64'(rdempty), 64'd0);
    check("t2_head_data", 64'(q_data), 64'h641225EB);
    check("t2_head_sop", 64'(q_sop), 64'd1);
    exp_q.push_back({32'h641225EB, 1'b1, 1'b0, 2'd0});
    exp_q.push_back({32'h1080809B, 1'b0, 1'b0, 2'd0});
    exp_q.push_back({32'h203D1474, 1'b0, 1'b1, 2'd2});
    mon_en = 1'b1;
    wait_drain("t2_drain");
    check("t2_empty_after", 64'(rdempty), 64'd1);

    // 3: errored frame dropped, following good frame intact
    frame(4, 32'h1000_0000, 1'b1, 1'b0);
    exp_drop = sat_inc(exp_drop);
    repeat (3) @(posedge clk);
    #1;
    check("t3_empty", 64'(rdempty), 64'd1);
    check("t3_drop", 64'(drop_count), 64'(exp_drop));
    frame(2, 32'h2000_0000, 1'b0, 1'b1);
    wait_drain("t3_drain");

    // 4: 20-word frame overflows 15-word capacity
    frame(20, 32'h3000_0000, 1'b0, 1'b0);
    exp_drop = sat_inc(exp_drop);
    repeat (3) @(posedge clk);
    #1;
    check("t4_empty", 64'(rdempty), 64'd1);
    check("t4_drop", 64'(drop_count), 64'(exp_drop));
    frame(5, 32'h4000_0000, 1'b0, 1'b1);
    wait_drain("t4_drain");

    // 5: missing eop, then orphan word
    send(32'h5000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    send(32'h5000_0001, 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'h5000_0002, 1'b0, 1'b0, 2'd0, 1'b0);
    frame(2, 32'h6000_0000, 1'b0, 1'b1);
    exp_drop = sat_inc(exp_drop);
    wait_drain("t5_drain");
    check("t5_drop", 64'(drop_count), 64'(exp_drop));
    send(32'h7000_0000, 1'b0, 1'b1, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_orphan_empty", 64'(rdempty), 64'd1);
    check("t5_orphan_drop", 64'(drop_count), 64'(exp_drop));

    // 6: saturation and clear priority, 1-word frames
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_drop = 0;
    check("t6_cleared", 64'(drop_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      frame(1, 32'h8000_0000 + 32'(i), 1'b1, 1'b0);
      exp_drop = sat_inc(exp_drop);
      if (i == 1) check("t6_drop2", 64'(drop_count), 64'(exp_drop));
    end
    check("t6_saturated", 64'(drop_count), 64'd3);
    clear = 1'b1;
    frame(1, 32'h9000_0000, 1'b1, 1'b0);
    clear = 1'b0;
    exp_drop = 0;
    check("t6_clear_prio", 64'(drop_count), 64'(exp_drop));
    frame(1, 32'hA000_0000, 1'b0, 1'b1);
    wait_drain("t6_single_drain");
    check("t6_final_empty", 64'(rdempty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
